// File: rtl/masking_pkg.sv
// Shared types and share-vector helpers for the masked conversion datapath.
// Share k of a packed vector lives at [k*kw +: kw].
package masking_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AND0,
      KS,
      ADD,
      DONE
   } state_t;

   localparam int MAX_W = 512;

   function automatic int randnum(input int n);
      return n * (n - 1);
   endfunction

   function automatic int log2k(input int k);
      return $clog2(k);
   endfunction

   // Shift every share left by d inside its own lane, zero-filling.
   function automatic logic [MAX_W-1:0] shl_sh(
      input logic [MAX_W-1:0] x,
      input int               kw,
      input int               d
   );
      logic [MAX_W-1:0] o;
      o = '0;
      for (int i = 0; i < MAX_W; i++)
         if ((i % kw) >= d) o[i] = x[i-d];
      return o;
   endfunction

   function automatic logic [MAX_W-1:0] pick_sh(
      input logic [MAX_W-1:0] x,
      input int               kw,
      input int               k
   );
      logic [MAX_W-1:0] o;
      o = '0;
      for (int i = 0; i < MAX_W; i++)
         if ((i / kw) == k) o[i] = x[i];
      return o;
   endfunction

endpackage

// File: rtl/sec_and_reg.sv
// Registered N-share masked AND gadget, one cycle latency.
// Pair p uses rnd1 word p and rnd2 word NP+p.
module sec_and_reg
   import masking_pkg::*;
#(
   parameter int K_WIDTH  = 32,
   parameter int N_SHARES = 3,
   parameter int RANDNUM  = randnum(N_SHARES)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [K_WIDTH*N_SHARES-1:0]  x,
   input  logic [K_WIDTH*N_SHARES-1:0]  y,
   input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
   output logic [K_WIDTH*N_SHARES-1:0]  q
);

   localparam int NP = RANDNUM / 2;

   logic [K_WIDTH*N_SHARES-1:0] w_z;
   logic [K_WIDTH*N_SHARES-1:0] r_q;

   always_comb begin
      w_z = '0;
      for (int i = 0; i < N_SHARES; i++)
         w_z[i*K_WIDTH +: K_WIDTH] = x[i*K_WIDTH +: K_WIDTH]
                                   & y[i*K_WIDTH +: K_WIDTH];
      for (int i = 0; i < N_SHARES; i++) begin
         for (int j = i + 1; j < N_SHARES; j++) begin
            // Each mask word lands in both shares of the pair and cancels.
            w_z[i*K_WIDTH +: K_WIDTH] = w_z[i*K_WIDTH +: K_WIDTH]
               ^ (x[i*K_WIDTH +: K_WIDTH] & y[j*K_WIDTH +: K_WIDTH])
               ^ rnd[(i*N_SHARES - i*(i+1)/2 + j-i-1)*K_WIDTH +: K_WIDTH]
               ^ rnd[(NP + i*N_SHARES - i*(i+1)/2 + j-i-1)*K_WIDTH +: K_WIDTH];
            w_z[j*K_WIDTH +: K_WIDTH] = w_z[j*K_WIDTH +: K_WIDTH]
               ^ (x[j*K_WIDTH +: K_WIDTH] & y[i*K_WIDTH +: K_WIDTH])
               ^ rnd[(i*N_SHARES - i*(i+1)/2 + j-i-1)*K_WIDTH +: K_WIDTH]
               ^ rnd[(NP + i*N_SHARES - i*(i+1)/2 + j-i-1)*K_WIDTH +: K_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  r_q <= '0;
      else if (en) r_q <= w_z;
   end

   assign q = r_q;

endmodule

// File: rtl/masked_a2b_conv.sv
// Arithmetic-to-Boolean share conversion via masked Kogge-Stone adders.
// Optional output refresh: define A2B_OUT_REFRESH_EN (adds rnd_ref port).
module masked_a2b_conv
   import masking_pkg::*;
#(
   parameter int K_WIDTH   = 32,
   parameter int N_SHARES  = 3,
   parameter int MASKWIDTH = K_WIDTH * N_SHARES,
   parameter int RANDNUM   = randnum(N_SHARES)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic                           dvld,
   input  logic [MASKWIDTH-1:0]           a,
   input  logic [2*K_WIDTH*RANDNUM-1:0]   rnd,
`ifdef A2B_OUT_REFRESH_EN
   input  logic [K_WIDTH*(N_SHARES-1)-1:0] rnd_ref,
`endif
   output logic                           rdy,
   output logic [MASKWIDTH-1:0]           b,
   output logic                           ovld
);

   localparam int LOG2K = log2k(K_WIDTH);
   localparam int IDXW  = $clog2(N_SHARES);
   localparam int RW    = K_WIDTH * RANDNUM;

   state_t                 r_state;
   logic [MASKWIDTH-1:0]   r_a;
   logic [MASKWIDTH-1:0]   r_s;
   logic [MASKWIDTH-1:0]   r_gacc;
   logic [MASKWIDTH-1:0]   r_b;
   logic [LOG2K-1:0]       r_round;
   logic [IDXW-1:0]        r_idx;
   logic                   r_ovld;

   logic [MASKWIDTH-1:0]   w_y, w_g, w_p, w_gs, w_ps, w_g1, w_ones;
   logic [MASKWIDTH-1:0]   w_x0, w_y0, w_x1, w_y1, w_q0, w_q1;
   logic [MASKWIDTH-1:0]   w_ref;
   logic                   w_gen;

   assign w_ones = MASKWIDTH'({K_WIDTH{1'b1}});
   assign w_y    = MASKWIDTH'(pick_sh(MAX_W'(r_a), K_WIDTH, int'(r_idx)));
   // G lives as accumulator ^ latest gadget term; P is gadget 1's output.
   assign w_g    = r_gacc ^ w_q0;
   assign w_p    = w_q1;
   assign w_gs   = MASKWIDTH'(shl_sh(MAX_W'(w_g), K_WIDTH, 1 << r_round));
   assign w_ps   = MASKWIDTH'(shl_sh(MAX_W'(w_p), K_WIDTH, 1 << r_round));
   assign w_g1   = MASKWIDTH'(shl_sh(MAX_W'(w_g), K_WIDTH, 1));
   assign w_gen  = ena & ((r_state == AND0) | (r_state == KS));

   always_comb begin
      w_x0 = '0;
      w_y0 = '0;
      w_x1 = '0;
      w_y1 = '0;
      unique case (r_state)
         AND0: begin
            // P = (S^Y) & ones: registers P through the gadget unchanged.
            w_x0 = r_s;
            w_y0 = w_y;
            w_x1 = r_s ^ w_y;
            w_y1 = w_ones;
         end
         KS: begin
            w_x0 = w_p;
            w_y0 = w_gs;
            w_x1 = w_p;
            w_y1 = w_ps;
         end
         default: ;
      endcase
   end

   sec_and_reg #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .RANDNUM(RANDNUM))
   u_and0 (
      .clk(clk), .rst_n(rst_n), .en(w_gen),
      .x(w_x0), .y(w_y0), .rnd(rnd[0 +: RW]), .q(w_q0)
   );

   sec_and_reg #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES), .RANDNUM(RANDNUM))
   u_and1 (
      .clk(clk), .rst_n(rst_n), .en(w_gen),
      .x(w_x1), .y(w_y1), .rnd(rnd[RW +: RW]), .q(w_q1)
   );

`ifdef A2B_OUT_REFRESH_EN
   always_comb begin
      w_ref = '0;
      for (int k = 0; k < N_SHARES - 1; k++) begin
         w_ref[k*K_WIDTH +: K_WIDTH] = rnd_ref[k*K_WIDTH +: K_WIDTH];
         w_ref[(N_SHARES-1)*K_WIDTH +: K_WIDTH] =
            w_ref[(N_SHARES-1)*K_WIDTH +: K_WIDTH]
            ^ rnd_ref[k*K_WIDTH +: K_WIDTH];
      end
   end
`else
   assign w_ref = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_s     <= '0;
         r_gacc  <= '0;
         r_b     <= '0;
         r_round <= '0;
         r_idx   <= '0;
         r_ovld  <= 1'b0;
      end else if (!ena) begin
         r_ovld <= 1'b0;
      end else begin
         r_ovld <= 1'b0;
         unique case (r_state)
            IDLE: if (dvld) begin
               r_a     <= a;
               r_s     <= MASKWIDTH'(a[K_WIDTH-1:0]);
               r_idx   <= IDXW'(1);
               r_round <= '0;
               r_state <= AND0;
            end
            AND0: begin
               r_gacc  <= '0;
               r_state <= KS;
            end
            KS: begin
               r_gacc <= w_g;
               if (r_round == LOG2K'(LOG2K - 1)) begin
                  r_round <= '0;
                  r_state <= ADD;
               end else begin
                  r_round <= r_round + 1'b1;
               end
            end
            ADD: begin
               r_s <= r_s ^ w_y ^ w_g1;
               if (r_idx == IDXW'(N_SHARES - 1)) begin
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= AND0;
               end
            end
            DONE: begin
               r_b     <= r_s ^ w_ref;
               r_ovld  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rdy  = (r_state == IDLE);
   assign b    = r_b;
   assign ovld = r_ovld;

endmodule

// File: tb/tb_masked_a2b_conv.sv
// Randomized bench for masked_a2b_conv against a modular-sum reference.
// XOR of output shares must equal the sum of input shares mod 2^K.
module tb_masked_a2b_conv;

   localparam int K  = 32;
   localparam int N  = 3;
   localparam int MW = K * N;
   localparam int RN = N * (N - 1);
   localparam int RW = 2 * K * RN;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena   = 1'b0;
   logic          dvld  = 1'b0;
   logic [MW-1:0] a     = '0;
   logic [RW-1:0] rnd   = '0;
   logic          rdy;
   logic          ovld;
   logic [MW-1:0] b;
`ifdef A2B_OUT_REFRESH_EN
   logic [K*(N-1)-1:0] rnd_ref = '0;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int rmode = 0;

   always #5 clk = ~clk;

   masked_a2b_conv #(.K_WIDTH(K), .N_SHARES(N)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .dvld(dvld),
      .a(a),
      .rnd(rnd),
`ifdef A2B_OUT_REFRESH_EN
      .rnd_ref(rnd_ref),
`endif
      .rdy(rdy),
      .b(b),
      .ovld(ovld)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [K-1:0] xor_sh(input logic [MW-1:0] v);
      logic [K-1:0] x;
      x = '0;
      for (int k = 0; k < N; k++) x = x ^ v[k*K +: K];
      return x;
   endfunction

   function automatic logic [K-1:0] ref_sum(input logic [MW-1:0] v);
      logic [K-1:0] s;
      s = '0;
      for (int k = 0; k < N; k++) s = s + v[k*K +: K];
      return s;
   endfunction

   function automatic logic [MW-1:0] pack3(input logic [K-1:0] s0,
                                           input logic [K-1:0] s1,
                                           input logic [K-1:0] s2);
      return {s2, s1, s0};
   endfunction

   task automatic drive_rnd();
      for (int w = 0; w < RW / 32; w++)
         case (rmode)
            1:       rnd[w*32 +: 32] = '0;
            2:       rnd[w*32 +: 32] = '1;
            default: rnd[w*32 +: 32] = $urandom;
         endcase
`ifdef A2B_OUT_REFRESH_EN
      for (int w = 0; w < (K*(N-1)) / 32; w++)
         rnd_ref[w*32 +: 32] = $urandom;
`endif
   endtask

   // One conversion, watched for a fixed 40-cycle window after accept.
   task automatic conv(input logic [MW-1:0] av, input int stall_at,
                       input int busy_at, input int rst_at,
                       output int lat, output int nov,
                       output logic [K-1:0] res);
      lat = -1;
      nov = 0;
      res = '0;
      a    = av;
      dvld = 1'b1;
      drive_rnd();
      @(posedge clk);
      #1;
      dvld = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         drive_rnd();
         @(posedge clk);
         #1;
         if (ovld) begin
            nov++;
            if (lat < 0) begin
               lat = c;
               res = xor_sh(b);
            end
         end
         if (c == stall_at)     ena = 1'b0;
         if (c == stall_at + 5) ena = 1'b1;
         if (c == busy_at) begin
            dvld = 1'b1;
            a    = {$urandom, $urandom, $urandom};
         end
         if (c == busy_at + 1)  dvld = 1'b0;
         if (c == rst_at)       rst_n = 1'b0;
         if (c == rst_at + 2)   rst_n = 1'b1;
      end
      ena  = 1'b1;
      dvld = 1'b0;
   endtask

   logic [MW-1:0] tv [3];
   logic [K-1:0]  te [3];
   logic [MW-1:0] av;
   logic [K-1:0]  res;
   int            lat, nov;

   initial begin
      tv[0] = pack3(32'd1, 32'd2, 32'd3);
      te[0] = 32'h0000_0006;
      tv[1] = pack3(32'hFFFF_FFFF, 32'd1, 32'd0);
      te[1] = 32'h0000_0000;
      tv[2] = pack3(32'h7FFF_FFFF, 32'd1, 32'd0);
      te[2] = 32'h8000_0000;

      repeat (3) @(posedge clk);
      #1;
      check("ovld_in_rst", 64'(ovld), 64'd0);
      check("b_in_rst", 64'(xor_sh(b)), 64'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      @(posedge clk);
      #1;
      check("rdy_rst", 64'(rdy), 64'd1);
      check("ovld_rst", 64'(ovld), 64'd0);
      check("b_rst", 64'(b[63:0]), 64'd0);

      for (int m = 0; m < 3; m++) begin
         rmode = m;
         for (int t = 0; t < 3; t++) begin
            conv(tv[t], -10, -10, -10, lat, nov, res);
            check($sformatf("lat_m%0d_t%0d", m, t), 64'(lat), 64'd15);
            check($sformatf("nov_m%0d_t%0d", m, t), 64'(nov), 64'd1);
            check($sformatf("res_m%0d_t%0d", m, t), 64'(res), 64'(te[t]));
         end
      end
      rmode = 0;

      conv(tv[2], 3, -10, -10, lat, nov, res);
      check("stall_lat", 64'(lat), 64'd20);
      check("stall_nov", 64'(nov), 64'd1);
      check("stall_res", 64'(res), 64'(te[2]));

      conv(tv[0], -10, -10, 7, lat, nov, res);
      check("rst_nov", 64'(nov), 64'd0);
      check("rst_b", 64'(b[63:0]), 64'd0);
      check("rst_b_hi", 64'(b[MW-1:64]), 64'd0);
      check("rst_rdy", 64'(rdy), 64'd1);

      conv(tv[1], -10, -10, -10, lat, nov, res);
      check("after_rst_lat", 64'(lat), 64'd15);
      check("after_rst_res", 64'(res), 64'(te[1]));

      conv(tv[0], -10, 5, -10, lat, nov, res);
      check("busy_nov", 64'(nov), 64'd1);
      check("busy_res", 64'(res), 64'(te[0]));
      check("busy_rdy_idle", 64'(rdy), 64'd1);

      for (int i = 0; i < 20; i++) begin
         av = {$urandom, $urandom, $urandom};
         conv(av, -10, -10, -10, lat, nov, res);
         check($sformatf("rand_lat_%0d", i), 64'(lat), 64'd15);
         check($sformatf("rand_res_%0d", i), 64'(res), 64'(ref_sum(av)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
